// File: rtl/painterengine_gpu_defs.sv
// Shared encodings for the GPU reader: FSM states, AXI constants, page geometry.
package painterengine_gpu_defs;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CALC  = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_WORDS = PAGE_BYTES / 4;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Beats for the next burst: smallest of words left, MAX_BURST, and words to the 4 KB page end.
module painterengine_gpu_burst_calc
    import painterengine_gpu_defs::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [15:0] remaining,
    input  logic [9:0]  word_offset,
    output logic [15:0] beats
);

    logic [15:0] page_beats;
    logic [15:0] cap;

    always_comb begin
        page_beats = 16'(PAGE_WORDS) - {6'd0, word_offset};
        cap        = (remaining < 16'(MAX_BURST)) ? remaining : 16'(MAX_BURST);
        beats      = (cap < page_beats) ? cap : page_beats;
    end

endmodule

// File: rtl/painterengine_gpu_reader.sv
// Read-DMA responder: splits a pixel job into page-safe AXI4 INCR bursts and streams beats to a FIFO.
module painterengine_gpu_reader
    import painterengine_gpu_defs::*;
#(
    parameter int MAX_BURST  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_resetn,
    input  logic                  i_wire_job_resetn,
    input  logic [ADDR_WIDTH-1:0] i_wire_address,
    input  logic [31:0]           i_wire_length,
    output logic                  o_wire_done,
    output logic                  o_wire_error,
    output logic [ADDR_WIDTH-1:0] o_wire_m_axi_araddr,
    output logic [7:0]            o_wire_m_axi_arlen,
    output logic [2:0]            o_wire_m_axi_arsize,
    output logic [1:0]            o_wire_m_axi_arburst,
    output logic                  o_wire_m_axi_arvalid,
    input  logic                  i_wire_m_axi_arready,
    input  logic [31:0]           i_wire_m_axi_rdata,
    input  logic [1:0]            i_wire_m_axi_rresp,
    input  logic                  i_wire_m_axi_rlast,
    input  logic                  i_wire_m_axi_rvalid,
    output logic                  o_wire_m_axi_rready,
    output logic                  o_wire_fifo_wr_en,
    output logic [31:0]           o_wire_fifo_wr_data,
    input  logic                  i_wire_fifo_full,
    output logic [31:0]           o_wire_state
);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           remaining;
    logic [15:0]           beat_cnt;
    logic [15:0]           beats;
    logic                  abort_pend;
    logic                  err_drained;
    logic                  rready;
    logic                  r_accept;
    logic                  length_unused;

    assign length_unused = ^i_wire_length[31:16];

    painterengine_gpu_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
        .remaining   (remaining),
        .word_offset (addr[11:2]),
        .beats       (beats)
    );

    // R-channel handshake is purely combinational so a push never lands on a full FIFO.
    always_comb begin
        rready = 1'b0;
        case (state)
            ST_DATA:           rready = !i_wire_fifo_full;
            ST_ERROR, ST_DRAIN: rready = 1'b1;
            default:           rready = 1'b0;
        endcase
        r_accept             = i_wire_m_axi_rvalid & rready;
        o_wire_m_axi_rready  = rready;
        o_wire_fifo_wr_en    = (state == ST_DATA) & i_wire_job_resetn & r_accept;
        o_wire_fifo_wr_data  = o_wire_fifo_wr_en ? i_wire_m_axi_rdata : 32'd0;
        o_wire_m_axi_arvalid = (state == ST_ADDR);
        o_wire_m_axi_arsize  = SIZE_4B;
        o_wire_m_axi_arburst = BURST_INCR;
        o_wire_done          = (state == ST_DONE);
        o_wire_error         = (state == ST_ERROR);
        o_wire_state         = {29'd0, state};
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state               <= ST_IDLE;
            addr                <= '0;
            remaining           <= '0;
            beat_cnt            <= '0;
            o_wire_m_axi_araddr <= '0;
            o_wire_m_axi_arlen  <= '0;
            abort_pend          <= 1'b0;
            err_drained         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (i_wire_job_resetn) begin
                    addr        <= i_wire_address;
                    remaining   <= i_wire_length[15:0];
                    err_drained <= 1'b0;
                    state       <= (i_wire_length[15:0] == 16'd0) ? ST_DONE : ST_CALC;
                end
                ST_CALC: if (!i_wire_job_resetn) begin
                    state <= ST_IDLE;
                end else begin
                    o_wire_m_axi_araddr <= addr;
                    o_wire_m_axi_arlen  <= 8'(beats - 16'd1);
                    beat_cnt            <= beats;
                    abort_pend          <= 1'b0;
                    state               <= ST_ADDR;
                end
                ST_ADDR: begin
                    // An abort here must still complete the AR handshake, so remember it.
                    if (!i_wire_job_resetn) abort_pend <= 1'b1;
                    if (i_wire_m_axi_arready) begin
                        addr      <= addr + ADDR_WIDTH'({beat_cnt, 2'b00});
                        remaining <= remaining - beat_cnt;
                        state     <= (abort_pend || !i_wire_job_resetn) ? ST_DRAIN : ST_DATA;
                    end
                end
                ST_DATA: if (r_accept) begin
                    beat_cnt <= beat_cnt - 16'd1;
                    if (!i_wire_job_resetn) begin
                        state <= i_wire_m_axi_rlast ? ST_IDLE : ST_DRAIN;
                    end else if (i_wire_m_axi_rresp != RESP_OKAY ||
                                 i_wire_m_axi_rlast != (beat_cnt == 16'd1)) begin
                        state       <= ST_ERROR;
                        err_drained <= i_wire_m_axi_rlast;
                    end else if (i_wire_m_axi_rlast) begin
                        state <= (remaining == 16'd0) ? ST_DONE : ST_CALC;
                    end
                end else if (!i_wire_job_resetn) begin
                    state <= ST_DRAIN;
                end
                ST_DONE: if (!i_wire_job_resetn) state <= ST_IDLE;
                ST_ERROR: begin
                    if (r_accept && i_wire_m_axi_rlast) err_drained <= 1'b1;
                    if (err_drained && !i_wire_job_resetn) state <= ST_IDLE;
                end
                ST_DRAIN: if (r_accept && i_wire_m_axi_rlast) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_reader.sv
// Scoreboarded bench: AXI read slave model, FIFO/AR monitors, directed job vectors.
module tb_painterengine_gpu_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        job_resetn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] length = '0;
    logic        done, error;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        fifo_full;
    logic [31:0] state;

    always #5 clk = ~clk;

    painterengine_gpu_reader #(.MAX_BURST(16), .ADDR_WIDTH(32)) dut (
        .i_wire_clock         (clk),
        .i_wire_resetn        (resetn),
        .i_wire_job_resetn    (job_resetn),
        .i_wire_address       (address),
        .i_wire_length        (length),
        .o_wire_done          (done),
        .o_wire_error         (error),
        .o_wire_m_axi_araddr  (araddr),
        .o_wire_m_axi_arlen   (arlen),
        .o_wire_m_axi_arsize  (arsize),
        .o_wire_m_axi_arburst (arburst),
        .o_wire_m_axi_arvalid (arvalid),
        .i_wire_m_axi_arready (arready),
        .i_wire_m_axi_rdata   (rdata),
        .i_wire_m_axi_rresp   (rresp),
        .i_wire_m_axi_rlast   (rlast),
        .i_wire_m_axi_rvalid  (rvalid),
        .o_wire_m_axi_rready  (rready),
        .o_wire_fifo_wr_en    (wr_en),
        .o_wire_fifo_wr_data  (wr_data),
        .i_wire_fifo_full     (fifo_full),
        .o_wire_state         (state)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_data_q[$];
    logic [39:0] exp_ar_q[$];

    // slave model state
    logic [31:0] bq_addr[$];
    logic [7:0]  bq_len[$];
    int beat_idx  = 0;
    int g_beat    = 0;
    int full_beat = 0;
    int full_left = 0;
    int err_beat  = 0;
    bit ar_slow   = 0;
    int cyc       = 0;

    // monitor counters
    int push_cnt = 0, ar_cnt = 0, stall_cyc = 0, full_push = 0, drain_bad = 0, ar_hold_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin : slave
        logic ar_hs, r_hs;
        logic [31:0] cap_addr;
        logic [7:0]  cap_len;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; fifo_full = 0;
        forever begin
            @(negedge clk);
            ar_hs    = arvalid && arready;
            r_hs     = rvalid && rready;
            cap_addr = araddr;
            cap_len  = arlen;
            @(posedge clk); #1;
            cyc++;
            if (!resetn) begin
                bq_addr.delete(); bq_len.delete();
                beat_idx = 0; g_beat = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; fifo_full = 0;
            end else begin
                if (ar_hs) begin
                    bq_addr.push_back(cap_addr);
                    bq_len.push_back(cap_len);
                end
                if (r_hs && bq_addr.size() > 0) begin
                    g_beat++;
                    if (beat_idx == int'(bq_len[0])) begin
                        void'(bq_addr.pop_front());
                        void'(bq_len.pop_front());
                        beat_idx = 0;
                    end else beat_idx++;
                end
                if (!job_resetn && bq_addr.size() == 0) g_beat = 0;
                arready = ar_slow ? (cyc % 3 == 0) : 1'b1;
                if (bq_addr.size() > 0) begin
                    rvalid = 1;
                    rdata  = bq_addr[0] + 32'(4 * beat_idx);
                    rlast  = (beat_idx == int'(bq_len[0]));
                    rresp  = (g_beat + 1 == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
                end
                if (full_left > 0 && g_beat + 1 == full_beat) begin
                    fifo_full = 1; full_left--;
                end else fifo_full = 0;
            end
        end
    end

    initial begin : monitor
        logic        prev_pend = 0;
        logic [39:0] prev_ar = '0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (wr_en) begin
                    push_cnt++;
                    if (exp_data_q.size() == 0) chk("push_extra", {32'd0, wr_data}, 64'hDEAD);
                    else chk("push_data", {32'd0, wr_data}, {32'd0, exp_data_q.pop_front()});
                    if (fifo_full) full_push++;
                end
                if (prev_pend && !(arvalid && {arlen, araddr} == prev_ar)) ar_hold_bad++;
                if (arvalid && arready) begin
                    ar_cnt++;
                    if (exp_ar_q.size() == 0) chk("ar_extra", {24'd0, arlen, araddr}, 64'hDEAD);
                    else chk("ar_req", {24'd0, arlen, araddr}, {24'd0, exp_ar_q.pop_front()});
                end
                if (state == 32'd3 && !rready) stall_cyc++;
                if (state == 32'd6 && (!rready || wr_en)) drain_bad++;
                prev_pend = arvalid && !arready;
                prev_ar   = {arlen, araddr};
            end else prev_pend = 0;
        end
    end

    task automatic wait_state(input string name, input logic [31:0] s);
        int n = 0;
        while (state !== s && n < 2000) begin @(negedge clk); n++; end
        chk(name, {32'd0, state}, {32'd0, s});
    endtask

    task automatic start_job(input logic [31:0] a, input logic [31:0] l);
        @(posedge clk); #1;
        address = a; length = l; job_resetn = 1;
        push_cnt = 0; ar_cnt = 0; stall_cyc = 0; full_push = 0; drain_bad = 0; ar_hold_bad = 0;
    endtask

    task automatic end_job(input string name);
        @(posedge clk); #1;
        job_resetn = 0;
        wait_state(name, 32'd0);
    endtask

    task automatic wait_bus_idle();
        int n = 0;
        while ((bq_addr.size() != 0 || rvalid) && n < 2000) begin @(negedge clk); n++; end
        chk("bus_idle", 64'(bq_addr.size()), 64'd0);
    endtask

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_state",   {32'd0, state}, 64'd0);
        chk("rst_outs",    {59'd0, done, error, arvalid, rready, wr_en}, 64'd0);
        chk("rst_araddr",  {24'd0, arlen, araddr}, 64'd0);
        chk("rst_consts",  {59'd0, arsize, arburst}, {59'd0, 3'b010, 2'b01});
        @(posedge clk); #1 resetn = 1;

        // T1: 64 words, 4 full bursts
        for (int i = 0; i < 64; i++) exp_data_q.push_back(32'h1000_0000 + 32'(4 * i));
        exp_ar_q.push_back({8'd15, 32'h1000_0000});
        exp_ar_q.push_back({8'd15, 32'h1000_0040});
        exp_ar_q.push_back({8'd15, 32'h1000_0080});
        exp_ar_q.push_back({8'd15, 32'h1000_00C0});
        start_job(32'h1000_0000, 32'd64);
        wait_state("t1_state", 32'd4);
        chk("t1_done",   {62'd0, done, error}, 64'd2);
        chk("t1_pushes", 64'(push_cnt), 64'd64);
        chk("t1_ars",    64'(ar_cnt), 64'd4);
        end_job("t1_idle");

        // T2: 4 KB boundary split, slow arready
        ar_slow = 1;
        for (int i = 0; i < 8; i++) exp_data_q.push_back(32'h1000_0FF0 + 32'(4 * i));
        exp_ar_q.push_back({8'd3, 32'h1000_0FF0});
        exp_ar_q.push_back({8'd3, 32'h1000_1000});
        start_job(32'h1000_0FF0, 32'd8);
        wait_state("t2_state", 32'd4);
        chk("t2_pushes", 64'(push_cnt), 64'd8);
        chk("t2_ar_hold", 64'(ar_hold_bad), 64'd0);
        ar_slow = 0;
        end_job("t2_idle");

        // T3: FIFO full while beat 5 is pending, for 5 cycles
        full_beat = 5; full_left = 5;
        for (int i = 0; i < 16; i++) exp_data_q.push_back(32'h2000_0000 + 32'(4 * i));
        exp_ar_q.push_back({8'd15, 32'h2000_0000});
        start_job(32'h2000_0000, 32'd16);
        wait_state("t3_state", 32'd4);
        chk("t3_stalls",    64'(stall_cyc), 64'd5);
        chk("t3_full_push", 64'(full_push), 64'd0);
        chk("t3_pushes",    64'(push_cnt), 64'd16);
        full_beat = 0;
        end_job("t3_idle");

        // T4: SLVERR on beat 3
        err_beat = 3;
        for (int i = 0; i < 3; i++) exp_data_q.push_back(32'h3000_0000 + 32'(4 * i));
        exp_ar_q.push_back({8'd15, 32'h3000_0000});
        start_job(32'h3000_0000, 32'd16);
        wait_state("t4_state", 32'd5);
        wait_bus_idle();
        chk("t4_flags",  {62'd0, done, error}, 64'd1);
        chk("t4_pushes", 64'(push_cnt), 64'd3);
        chk("t4_beats",  64'(g_beat), 64'd16);
        err_beat = 0;
        end_job("t4_idle");

        // T5: abort after 4 pushes, then restart
        for (int i = 0; i < 4; i++) exp_data_q.push_back(32'h4000_0000 + 32'(4 * i));
        exp_ar_q.push_back({8'd15, 32'h4000_0000});
        start_job(32'h4000_0000, 32'd16);
        n = 0;
        while (push_cnt < 4 && n < 500) begin @(posedge clk); n++; end
        #1 job_resetn = 0;
        wait_state("t5_idle", 32'd0);
        chk("t5_bus_empty", 64'(bq_addr.size()), 64'd0);
        chk("t5_pushes",    64'(push_cnt), 64'd4);
        chk("t5_drain",     64'(drain_bad), 64'd0);
        for (int i = 0; i < 4; i++) exp_data_q.push_back(32'h4000_1000 + 32'(4 * i));
        exp_ar_q.push_back({8'd3, 32'h4000_1000});
        start_job(32'h4000_1000, 32'd4);
        wait_state("t5r_state", 32'd4);
        chk("t5r_pushes", 64'(push_cnt), 64'd4);
        end_job("t5r_idle");

        // T6: zero length
        start_job(32'h5000_0000, 32'd0);
        @(negedge clk);
        chk("t6_idle", {32'd0, state}, 64'd0);
        @(negedge clk);
        chk("t6_done", {31'd0, done, state}, {31'd0, 1'b1, 32'd4});
        chk("t6_ars",  64'(ar_cnt), 64'd0);
        end_job("t6_idle2");

        // T7: asynchronous reset mid-burst
        for (int i = 0; i < 16; i++) exp_data_q.push_back(32'h6000_0000 + 32'(4 * i));
        exp_ar_q.push_back({8'd15, 32'h6000_0000});
        start_job(32'h6000_0000, 32'd16);
        n = 0;
        while (push_cnt < 3 && n < 500) begin @(posedge clk); n++; end
        chk("t7_started", 64'(push_cnt >= 3), 64'd1);
        #3 resetn = 0;
        #1;
        chk("t7_ctrl",  {59'd0, done, error, arvalid, rready, wr_en}, 64'd0);
        chk("t7_data",  {32'd0, wr_data}, 64'd0);
        chk("t7_ar",    {24'd0, arlen, araddr}, 64'd0);
        chk("t7_state", {32'd0, state}, 64'd0);
        exp_data_q.delete();
        exp_ar_q.delete();
        job_resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
